connect4_turn_controller: RTL and testbench

//  Sequences one Connect-4 move at a time: accepts column pulses, finds the

---
 rtl/connect4_turn_controller_if.sv | 34 +++
 rtl/connect4_turn_controller.sv | 167 ++++++++++++++++
 tb/tb_connect4_turn_controller.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/connect4_turn_controller_if.sv
// Board access and win-check handshake between the Connect-4 turn controller
// (master) and the board storage / win checker (slave).
interface connect4_turn_controller_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_cell;

  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [1:0]    wr_data;

  logic          chk_req;
  logic [RW-1:0] chk_row;
  logic [CW-1:0] chk_col;
  logic          chk_done;
  logic          chk_win;

  modport master (
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, chk_req, chk_row, chk_col,
    input  rd_cell, chk_done, chk_win
  );

  modport slave (
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, chk_req, chk_row, chk_col,
    output rd_cell, chk_done, chk_win
  );
endinterface

// File: rtl/connect4_turn_controller.sv
// Connect-4 move sequencer: column pulse -> landing-row scan -> write -> win check -> next player.
// Optional macro AUTO_DROP_EN: an expired turn drops a piece in the first non-full column instead of forfeiting.
module connect4_turn_controller #(
  parameter int ROWS        = 6,
  parameter int COLS        = 7,
  parameter int TURN_CYCLES = 377_625_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COLS-1:0]             col_pulse,
  connect4_turn_controller_if.master  bus,
  output logic [1:0]                  jugador,
  output logic                        inserted,
  output logic                        col_full,
  output logic                        timeout,
  output logic                        juego_terminado,
  output logic [1:0]                  winner
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TURN_CYCLES - 1);
  localparam logic [RW-1:0] TOP_ROW      = RW'(ROWS - 1);
  localparam logic [5:0]    MAX_MOVES    = 6'(ROWS * COLS);
`ifdef AUTO_DROP_EN
  localparam logic [CW-1:0] LAST_COL     = CW'(COLS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    CHECK,
    SWITCH,
    OVER
  } state_t;

  state_t        state;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] scan_row;
  logic [RW-1:0] land_row;
  logic [TW-1:0] timer;
  logic [5:0]    moves;
  logic          write_strobe;
  logic          chk_req;
  logic [CW-1:0] pulse_col;
`ifdef AUTO_DROP_EN
  logic          auto_move;
`endif

  // Lowest requested column wins; higher simultaneous requests are dropped.
  always_comb begin
    pulse_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (col_pulse[i]) pulse_col = CW'(i);
    end
  end

  assign bus.rd_row  = scan_row;
  assign bus.rd_col  = cur_col;
  assign bus.wr_en   = write_strobe;
  assign bus.wr_row  = land_row;
  assign bus.wr_col  = cur_col;
  assign bus.wr_data = jugador;
  assign bus.chk_req = chk_req;
  assign bus.chk_row = land_row;
  assign bus.chk_col = cur_col;
  assign inserted    = write_strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      jugador         <= 2'b01;
      moves           <= '0;
      timer           <= TIMER_RELOAD;
      winner          <= 2'b00;
      cur_col         <= '0;
      scan_row        <= '0;
      land_row        <= '0;
      write_strobe    <= 1'b0;
      col_full        <= 1'b0;
      timeout         <= 1'b0;
      chk_req         <= 1'b0;
      juego_terminado <= 1'b0;
`ifdef AUTO_DROP_EN
      auto_move       <= 1'b0;
`endif
    end else begin
      write_strobe <= 1'b0;
      col_full     <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          if (timer != '0) timer <= timer - TW'(1);
          // A move request in the expiry cycle takes priority over the timeout.
          if (col_pulse != '0) begin
            cur_col  <= pulse_col;
            scan_row <= '0;
`ifdef AUTO_DROP_EN
            auto_move <= 1'b0;
`endif
            state    <= SCAN;
          end else if (timer == '0) begin
            timeout <= 1'b1;
`ifdef AUTO_DROP_EN
            cur_col   <= '0;
            scan_row  <= '0;
            auto_move <= 1'b1;
            state     <= SCAN;
`else
            state     <= SWITCH;
`endif
          end
        end
        SCAN: begin
          if (bus.rd_cell == 2'b00) begin
            land_row     <= scan_row;
            write_strobe <= 1'b1;
            state        <= WRITE;
          end else if (scan_row != TOP_ROW) begin
            scan_row <= scan_row + RW'(1);
`ifdef AUTO_DROP_EN
          end else if (auto_move && (cur_col != LAST_COL)) begin
            cur_col  <= cur_col + CW'(1);
            scan_row <= '0;
`endif
          end else begin
            col_full <= 1'b1;
            state    <= IDLE;
          end
        end
        WRITE: begin
          if (moves != 6'h3f) moves <= moves + 6'd1;
          chk_req <= 1'b1;
          state   <= CHECK;
        end
        CHECK: begin
          if (bus.chk_done) begin
            chk_req <= 1'b0;
            if (bus.chk_win) begin
              winner          <= jugador;
              juego_terminado <= 1'b1;
              state           <= OVER;
            end else if (moves == MAX_MOVES) begin
              winner          <= 2'b00;
              juego_terminado <= 1'b1;
              state           <= OVER;
            end else begin
              state <= SWITCH;
            end
          end
        end
        SWITCH: begin
          jugador <= (jugador == 2'b01) ? 2'b10 : 2'b01;
          timer   <= TIMER_RELOAD;
          state   <= IDLE;
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_connect4_turn_controller.sv
// Randomised self-checking bench for connect4_turn_controller; the reference is a
// column-height board model with a per-turn idle budget. Honours AUTO_DROP_EN if defined.
module tb_connect4_turn_controller;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int TC   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] col_pulse = '0;
  logic [1:0]      jugador;
  logic [1:0]      winner;
  logic            inserted;
  logic            col_full;
  logic            timeout;
  logic            juego_terminado;

  connect4_turn_controller_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  connect4_turn_controller #(.ROWS(ROWS), .COLS(COLS), .TURN_CYCLES(TC)) dut (
    .clk             (clk),
    .rst             (rst),
    .col_pulse       (col_pulse),
    .bus             (bus),
    .jugador         (jugador),
    .inserted        (inserted),
    .col_full        (col_full),
    .timeout         (timeout),
    .juego_terminado (juego_terminado),
    .winner          (winner)
  );

  always #5 clk = ~clk;

  // Board storage the DUT reads combinationally.
  logic [1:0] board [COLS][ROWS];
  assign bus.rd_cell = (int'(bus.rd_col) < COLS && int'(bus.rd_row) < ROWS) ?
                       board[bus.rd_col][bus.rd_row] : 2'b11;

  int  height [COLS];
  int  m_player, m_moves, m_tv, m_winner, m_cf, m_to, m_writes;
  bit  m_over, aborted;
  bit  g_allow_win;
  int  g_abort_at;
  int  vectors = 0;
  int  miscompares = 0;
  int  wr_seen, to_seen, cf_seen;
  int  wr_base, to_base, cf_base;

  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) wr_seen <= wr_seen + 1;
    if (timeout === 1'b1)   to_seen <= to_seen + 1;
    if (col_full === 1'b1)  cf_seen <= cf_seen + 1;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed no end of test, required finish within budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [COLS-1:0] m);
    for (int i = 0; i < COLS; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [COLS-1:0] pickMask();
    int open [$];
    logic [COLS-1:0] m;
    int c;
    for (int i = 0; i < COLS; i++) if (height[i] < ROWS) open.push_back(i);
    if (open.size() == 0 || $urandom_range(0, 2) == 0) begin
      do m = COLS'($urandom); while (m == '0);
      return m;
    end
    c = open[$urandom_range(0, open.size() - 1)];
    m = COLS'($urandom);
    for (int i = 0; i <= c; i++) m[i] = 1'b0;
    m[c] = 1'b1;
    return m;
  endfunction

  function automatic int pickDelay();
    if ($urandom_range(0, 4) == 0) return m_tv;
    return $urandom_range(0, (m_tv < 3) ? m_tv : 3);
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    col_pulse = '0;
    bus.chk_done = 1'b0;
    bus.chk_win = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      height[c] = 0;
      for (int r = 0; r < ROWS; r++) board[c][r] = 2'b00;
    end
    m_player = 1; m_moves = 0; m_tv = TC - 1; m_winner = 0;
    m_cf = 0; m_to = 0; m_writes = 0; m_over = 0; aborted = 0;
    tick();
    tick();
    checkOutput("rst_jugador", jugador, 1);
    checkOutput("rst_winner", winner, 0);
    checkOutput("rst_over", juego_terminado, 0);
    checkOutput("rst_chk_req", bus.chk_req, 0);
    checkOutput("rst_wr_en", bus.wr_en, 0);
    checkOutput("rst_timeout", timeout, 0);
    rst = 1'b0;
    wr_base = wr_seen; to_base = to_seen; cf_base = cf_seen;
  endtask

  // Follows one move from its first scan cycle through the check handshake.
  task automatic followMove(input int c, input int exp_lat);
    int n = 1;
    int r;
    int d;
    bit win;
    while (bus.wr_en !== 1'b1 && col_full !== 1'b1 && n < 60) begin
      col_pulse = COLS'($urandom);
      tick();
      col_pulse = '0;
      n++;
    end
    checkOutput("event_cycle", n, exp_lat);
    r = height[c];
    if (r >= ROWS) begin
      checkOutput("col_full", col_full, 1);
      checkOutput("no_write_full", bus.wr_en, 0);
      checkOutput("player_kept", jugador, m_player);
      m_cf++;
      return;
    end
    checkOutput("wr_en", bus.wr_en, 1);
    checkOutput("inserted", inserted, 1);
    checkOutput("wr_row", bus.wr_row, r);
    checkOutput("wr_col", bus.wr_col, c);
    checkOutput("wr_data", bus.wr_data, m_player);
    if (bus.wr_en === 1'b1 && int'(bus.wr_col) < COLS && int'(bus.wr_row) < ROWS)
      board[bus.wr_col][bus.wr_row] = bus.wr_data;
    height[c]++; m_moves++; m_writes++;
    tick();
    checkOutput("inserted_1cyc", inserted, 0);
    checkOutput("wr_en_1cyc", bus.wr_en, 0);
    checkOutput("chk_req", bus.chk_req, 1);
    checkOutput("chk_row", bus.chk_row, r);
    checkOutput("chk_col", bus.chk_col, c);
    if (m_writes == g_abort_at) begin
      rst = 1'b1;
      #2;
      checkOutput("abort_chk_req", bus.chk_req, 0);
      checkOutput("abort_jugador", jugador, 1);
      checkOutput("abort_wr_en", bus.wr_en, 0);
      aborted = 1;
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) begin
      col_pulse = COLS'($urandom);
      bus.chk_win = 1'($urandom);
      tick();
      col_pulse = '0;
      checkOutput("chk_hold", bus.chk_req, 1);
      checkOutput("chk_row_hold", bus.chk_row, r);
    end
    win = g_allow_win && ($urandom_range(0, 14) == 0);
    bus.chk_done = 1'b1;
    bus.chk_win = win;
    col_pulse = COLS'($urandom);
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win = 1'($urandom);
    col_pulse = '0;
    checkOutput("chk_release", bus.chk_req, 0);
    if (win) begin
      m_over = 1; m_winner = m_player;
    end else if (m_moves == ROWS * COLS) begin
      m_over = 1; m_winner = 0;
    end
    checkOutput("game_over", juego_terminado, m_over);
    checkOutput("winner", winner, m_winner);
    if (m_over) return;
    col_pulse = COLS'($urandom);
    tick();
    col_pulse = '0;
    m_player = 3 - m_player;
    m_tv = TC - 1;
    checkOutput("player_switch", jugador, m_player);
    checkOutput("wr_count", wr_seen - wr_base, m_writes);
  endtask

  task automatic applyStimulus(input logic [COLS-1:0] mask, input int k);
    int c;
    repeat (k) tick();
    m_tv -= k;
    col_pulse = mask;
    tick();
    col_pulse = '0;
    if (m_tv > 0) m_tv--;
    checkOutput("timeout_suppressed", timeout, 0);
    c = lowest(mask);
    followMove(c, (height[c] >= ROWS) ? ROWS + 1 : 2 + height[c]);
  endtask

  task automatic applyTimeout();
    int c0 = 0;
    repeat (m_tv) tick();
    checkOutput("timeout_early", timeout, 0);
    tick();
    checkOutput("timeout_fire", timeout, 1);
    m_to++;
`ifdef AUTO_DROP_EN
    while (c0 < COLS - 1 && height[c0] >= ROWS) c0++;
    followMove(c0, 2 + ROWS * c0 + height[c0]);
`else
    checkOutput("forfeit_no_write", bus.wr_en + c0, 0);
    tick();
    checkOutput("timeout_1cyc", timeout, 0);
    m_player = 3 - m_player;
    m_tv = TC - 1;
    checkOutput("forfeit_switch", jugador, m_player);
`endif
  endtask

  task automatic finishGame();
    if (m_over) begin
      repeat (20) begin
        col_pulse = COLS'($urandom);
        tick();
      end
      col_pulse = '0;
      checkOutput("over_held", juego_terminado, 1);
      checkOutput("over_winner", winner, m_winner);
    end else begin
      tick();
    end
    checkOutput("final_jugador", jugador, m_player);
    checkOutput("total_writes", wr_seen - wr_base, m_writes);
    checkOutput("total_timeouts", to_seen - to_base, m_to);
    checkOutput("total_col_full", cf_seen - cf_base, m_cf);
  endtask

  task automatic playGame(input int max_turns);
    int turns = 0;
    while (!m_over && !aborted && turns < max_turns) begin
      if ($urandom_range(0, 9) == 0) applyTimeout();
      else applyStimulus(pickMask(), pickDelay());
      turns++;
    end
    if (!aborted) finishGame();
  endtask

  initial begin
    logic [COLS-1:0] m;
    g_allow_win = 1; g_abort_at = -1;
    applyReset();
    m = COLS'(4);
    applyStimulus(m, 0);
    playGame(200);

    applyReset();
    g_allow_win = 0;
    playGame(600);

    applyReset();
    g_allow_win = 1;
    for (int r = 0; r < ROWS; r++) begin
      board[0][r] = (r % 2 == 0) ? 2'b01 : 2'b10;
      board[1][r] = (r % 2 == 0) ? 2'b10 : 2'b01;
    end
    for (int r = 0; r < 3; r++) board[3][r] = (r % 2 == 0) ? 2'b01 : 2'b10;
    height[0] = ROWS; height[1] = ROWS; height[3] = 3;
    m = COLS'(8);
    applyStimulus(m, 0);
    m = COLS'(1);
    if (!m_over) applyStimulus(m, 0);
    m = COLS'(3);
    if (!m_over) applyStimulus(m, 1);
    if (!m_over) applyTimeout();
    playGame(20);

    applyReset();
    g_allow_win = 0; g_abort_at = 4;
    playGame(100);

    applyReset();
    g_allow_win = 1; g_abort_at = -1;
    playGame(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
